// File: rtl/dexie_trace_buffer_if.sv
// rtl/dexie_trace_buffer_if.sv - merged DExIE trace event stream towards the checker fabric
interface dexie_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_kind;
  logic [XLEN-1:0] out_word0;
  logic [XLEN-1:0] out_word1;
  logic [4:0]      out_aux;

  modport master (
    output out_valid, out_kind, out_word0, out_word1, out_aux,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_word0, out_word1, out_aux,
    output out_ready
  );
endinterface

// File: rtl/dexie_trace_buffer.sv
// rtl/dexie_trace_buffer.sv - per-class trace FIFOs merged by a round-robin arbiter onto one stream
// Class index 0 = cf, 1 = mem, 2 = reg; entries are stored already formatted as output beats.
module dexie_trace_buffer #(
  parameter int         XLEN         = 32,
  parameter int         DEPTH        = 8,
  parameter int         STALL_MARGIN = 2,
  parameter logic [2:0] CLASS_EN     = 3'b111,
  parameter int         CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cf_valid,
  input  logic [XLEN-1:0]      cf_cur_pc,
  input  logic [XLEN-1:0]      cf_next_pc,
  input  logic                 mem_load,
  input  logic                 mem_store,
  input  logic [XLEN-1:0]      mem_addr,
  input  logic [1:0]           mem_len,
  input  logic [XLEN-1:0]      mem_storedata,
  input  logic                 reg_valid,
  input  logic [4:0]           reg_rd_addr,
  input  logic [XLEN-1:0]      reg_rd_val,
  input  logic                 ext_stall,
  input  logic                 hold_on_store,
  input  logic                 continue_store,
  input  logic                 clear,
  dexie_trace_buffer_if.master ev_out,
  output logic                 core_stall,
  output logic                 store_hold,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_CNT = CW'(DEPTH - STALL_MARGIN);

  localparam logic [1:0] K_CF    = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_REG   = 2'd3;

  typedef struct packed {
    logic [1:0]      kind;
    logic [4:0]      aux;
    logic [XLEN-1:0] word1;
    logic [XLEN-1:0] word0;
  } entry_t;

  typedef enum logic {S_IDLE, S_HOLD} hold_state_e;

  entry_t          fifo_q [3][DEPTH];
  logic [CW-1:0]   cnt    [3];
  logic [AW-1:0]   wr_ptr [3];
  logic [AW-1:0]   rd_ptr [3];
  logic [1:0]      rr_ptr;

  entry_t          out_q;
  logic            out_valid_q;
  logic            overflow_q;
  logic [CNT_W-1:0] drop_count_q;
  hold_state_e     hold_state;
  logic            store_hold_q;

  entry_t          push_entry [3];
  logic [2:0]      ev, full, avail, push, drop, near, pop;
  logic            grant_any, load_en;
  logic [1:0]      grant_idx, cand;
  entry_t          head;
  logic [1:0]      drop_n;
  logic [CNT_W-1:0] drop_base;
  logic [CNT_W:0]  drop_sum;
  logic [CNT_W-1:0] drop_next;

  function automatic logic [1:0] cls_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    ev[0] = cf_valid;
    ev[1] = mem_load | mem_store;
    ev[2] = reg_valid;

    push_entry[0] = '{kind: K_CF, aux: 5'd0, word1: cf_next_pc, word0: cf_cur_pc};
    push_entry[1] = '{kind: mem_store ? K_STORE : K_LOAD, aux: {3'b000, mem_len},
                      word1: mem_store ? mem_storedata : '0, word0: mem_addr};
    push_entry[2] = '{kind: K_REG, aux: reg_rd_addr, word1: '0, word0: reg_rd_val};

    full  = '0;
    avail = '0;
    push  = '0;
    drop  = '0;
    near  = '0;
    for (int i = 0; i < 3; i++) begin
      full[i]  = (cnt[i] == FULL_CNT);
      avail[i] = (cnt[i] != '0);
      push[i]  = CLASS_EN[i] && ev[i] && !full[i];
      drop[i]  = CLASS_EN[i] && ev[i] && full[i];
      near[i]  = CLASS_EN[i] && (cnt[i] >= NEAR_CNT);
    end

    // Search starts at rr_ptr, which always names the class after the last one granted.
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      cand = cls_add(rr_ptr, 2'(k));
      if (!grant_any && avail[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end

    head    = fifo_q[grant_idx][rd_ptr[grant_idx]];
    load_en = grant_any && (!out_valid_q || ev_out.out_ready);
    pop     = '0;
    for (int i = 0; i < 3; i++) begin
      pop[i] = load_en && (grant_idx == 2'(i));
    end

    // Clear takes effect first, so drops in the same cycle count up from zero.
    drop_n    = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    drop_base = clear ? '0 : drop_count_q;
    drop_sum  = {1'b0, drop_base} + {{(CNT_W-1){1'b0}}, drop_n};
    drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        fifo_q[i][wr_ptr[i]] <= push_entry[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr       <= 2'd0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      hold_state   <= S_IDLE;
      store_hold_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end

      if (load_en) begin
        out_valid_q <= 1'b1;
        out_q       <= head;
        rr_ptr      <= cls_add(grant_idx, 2'd1);
      end else if (ev_out.out_ready) begin
        out_valid_q <= 1'b0;
      end

      overflow_q   <= (overflow_q && !clear) || (|drop);
      drop_count_q <= drop_next;

      // Only a store that actually entered its FIFO arms the hold.
      case (hold_state)
        S_IDLE: begin
          if (push[1] && mem_store && hold_on_store) begin
            hold_state   <= S_HOLD;
            store_hold_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (continue_store) begin
            hold_state   <= S_IDLE;
            store_hold_q <= 1'b0;
          end
        end
        default: begin
          hold_state   <= S_IDLE;
          store_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign ev_out.out_valid = out_valid_q;
  assign ev_out.out_kind  = out_q.kind;
  assign ev_out.out_word0 = out_q.word0;
  assign ev_out.out_word1 = out_q.word1;
  assign ev_out.out_aux   = out_q.aux;

  // While reset is held only the external request may stall the core.
  assign core_stall = ext_stall || (!rst && (store_hold_q || (|near)));
  assign store_hold = store_hold_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_dexie_trace_buffer.sv
// tb/tb_dexie_trace_buffer.sv - directed vectors and scoreboarded traffic for dexie_trace_buffer
module tb_dexie_trace_buffer;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cf_valid;
  logic [31:0] cf_cur_pc, cf_next_pc;
  logic        mem_load, mem_store;
  logic [31:0] mem_addr, mem_storedata;
  logic [1:0]  mem_len;
  logic        reg_valid;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_val;
  logic        ext_stall, hold_on_store, continue_store, clear;
  logic        core_stall, store_hold, overflow;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  dexie_trace_buffer_if #(.XLEN(XLEN)) ev_out ();

  dexie_trace_buffer #(
    .XLEN(XLEN), .DEPTH(8), .STALL_MARGIN(2), .CLASS_EN(3'b111), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cf_valid(cf_valid), .cf_cur_pc(cf_cur_pc), .cf_next_pc(cf_next_pc),
    .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_storedata(mem_storedata),
    .reg_valid(reg_valid), .reg_rd_addr(reg_rd_addr), .reg_rd_val(reg_rd_val),
    .ext_stall(ext_stall), .hold_on_store(hold_on_store),
    .continue_store(continue_store), .clear(clear),
    .ev_out(ev_out),
    .core_stall(core_stall), .store_hold(store_hold),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        cf, ld, st, rg;
    logic [31:0] a, b;
    logic [4:0]  c;
    logic [1:0]  e_kind;
    logic [31:0] e_w0, e_w1;
    logic [4:0]  e_aux;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
    cf_cur_pc = a; mem_addr = a; reg_rd_val = a;
    cf_next_pc = b; mem_storedata = b;
    mem_len = c[1:0]; reg_rd_addr = c;
  endtask

  task automatic idle_events();
    cf_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0; reg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; idle_events();
    ext_stall = 1'b0; hold_on_store = 1'b0; continue_store = 1'b0; clear = 1'b0;
    ev_out.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [70:0] dut_beat();
    return {ev_out.out_kind, ev_out.out_aux, ev_out.out_word1, ev_out.out_word0};
  endfunction

  vec_t        vt [8];
  logic [70:0] q_cf[$], q_mem[$], q_reg[$];
  logic [70:0] prev, beat, exp_beat;
  logic [31:0] ra, rb;
  logic [4:0]  rc;
  logic        pend, have;
  int          pushed, recv, got, exp_pc, r;

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0200, 5'h1F, 2'd0, 32'h0000_0100, 32'h0000_0200, 5'd0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h55AA_55AA, 5'd1,  2'd1, 32'h0000_1000, 32'h0000_0000, 5'd1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 5'd2,  2'd2, 32'h8000_0000, 32'hDEAD_BEEF, 5'd2};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_1234, 5'd5,  2'd3, 32'h0000_0007, 32'h0000_0000, 5'd5};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 5'd31};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'd3,  2'd2, 32'h0000_0004, 32'h0000_0000, 5'd3};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_FFFF, 5'h1E, 2'd1, 32'h0000_000C, 32'h0000_0000, 5'd2};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 5'd7,  2'd0, 32'hFFFF_FFFC, 32'h0000_0000, 5'd0};

    rst = 1'b1; idle_events(); set_bus('0, '0, '0);
    ext_stall = 1'b1; hold_on_store = 1'b0; continue_store = 1'b0; clear = 1'b0;
    ev_out.out_ready = 1'b1;
    @(negedge clk);
    check("reset stall follows ext_stall hi", core_stall, 1'b1);
    ext_stall = 1'b0;
    #1;
    check("reset stall follows ext_stall lo", core_stall, 1'b0);
    check("reset out_valid", ev_out.out_valid, 1'b0);
    check("reset out data", dut_beat(), 71'd0);
    check("reset overflow", overflow, 1'b0);
    check("reset drop_count", drop_count, 16'd0);
    check("reset store_hold", store_hold, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_bus(vt[i].a, vt[i].b, vt[i].c);
      cf_valid = vt[i].cf; mem_load = vt[i].ld; mem_store = vt[i].st; reg_valid = vt[i].rg;
      @(negedge clk);
      idle_events();
      check($sformatf("vec%0d valid at t+1", i), ev_out.out_valid, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d valid at t+2", i), ev_out.out_valid, 1'b1);
      check($sformatf("vec%0d beat", i), dut_beat(), {vt[i].e_kind, vt[i].e_aux, vt[i].e_w1, vt[i].e_w0});
      @(negedge clk);
      check($sformatf("vec%0d consumed", i), ev_out.out_valid, 1'b0);
    end

    do_reset();
    cf_valid = 1'b1; cf_cur_pc = 32'h100; cf_next_pc = 32'h200;
    mem_store = 1'b1; mem_addr = 32'h8000_0000; mem_storedata = 32'hDEAD_BEEF; mem_len = 2'd2;
    reg_valid = 1'b1; reg_rd_addr = 5'd5; reg_rd_val = 32'd7;
    @(negedge clk);
    idle_events();
    check("burst t+1 empty", ev_out.out_valid, 1'b0);
    @(negedge clk);
    check("burst beat0", {ev_out.out_valid, dut_beat()}, {1'b1, 2'd0, 5'd0, 32'h200, 32'h100});
    @(negedge clk);
    check("burst beat1", {ev_out.out_valid, dut_beat()}, {1'b1, 2'd2, 5'd2, 32'hDEAD_BEEF, 32'h8000_0000});
    @(negedge clk);
    check("burst beat2", {ev_out.out_valid, dut_beat()}, {1'b1, 2'd3, 5'd5, 32'd0, 32'd7});
    @(negedge clk);
    check("burst drained", ev_out.out_valid, 1'b0);

    // One beat parks in the output register, so the FIFO count after event i is i-1.
    do_reset();
    ev_out.out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cf_valid = 1'b1; cf_cur_pc = 32'(i); cf_next_pc = 32'(i) + 32'h1000;
      @(negedge clk);
      check($sformatf("fill%0d core_stall", i), core_stall, (i >= 7));
      check($sformatf("fill%0d overflow", i), overflow, (i >= 10));
      check($sformatf("fill%0d drop_count", i), drop_count, (i >= 10) ? 16'(i - 9) : 16'd0);
    end
    cf_cur_pc = 32'hBAD; clear = 1'b1;
    @(negedge clk);
    check("clear with drop overflow", overflow, 1'b1);
    check("clear with drop count", drop_count, 16'd1);
    cf_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clear overflow", overflow, 1'b0);
    check("clear drop_count", drop_count, 16'd0);

    ev_out.out_ready = 1'b1;
    exp_pc = 1; got = 0;
    for (int c = 0; c < 30 && got < 9; c++) begin
      if (ev_out.out_valid) begin
        check("drain order", ev_out.out_word0, 32'(exp_pc));
        exp_pc++; got++;
      end
      @(negedge clk);
    end
    check("drain count", got, 9);
    check("drain empty", ev_out.out_valid, 1'b0);
    check("drain stall released", core_stall, 1'b0);

    do_reset();
    hold_on_store = 1'b1; continue_store = 1'b1;
    @(negedge clk);
    continue_store = 1'b0;
    check("continue ignored in idle", store_hold, 1'b0);
    set_bus(32'h2000, 32'h1234_5678, 5'd2); mem_store = 1'b1;
    @(negedge clk);
    idle_events(); hold_on_store = 1'b0;
    check("hold entered", {store_hold, core_stall}, 2'b11);
    @(negedge clk);
    check("hold persists", {store_hold, core_stall}, 2'b11);
    continue_store = 1'b1;
    #1;
    check("hold before release edge", store_hold, 1'b1);
    @(negedge clk);
    continue_store = 1'b0;
    check("hold released", {store_hold, core_stall}, 2'b00);

    do_reset();
    ev_out.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_bus(32'(i), 32'h0, 5'd0); mem_load = 1'b1;
      @(negedge clk);
    end
    mem_load = 1'b0; mem_store = 1'b1; hold_on_store = 1'b1;
    @(negedge clk);
    idle_events(); hold_on_store = 1'b0;
    check("dropped store no hold", store_hold, 1'b0);
    check("dropped store counted", drop_count, 16'd1);

    do_reset();
    pushed = 0; recv = 0; pend = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 20000 && (pushed < 1000 || recv < pushed); cyc++) begin
      if (pend) check("backpressure stable", {ev_out.out_valid, dut_beat()}, {1'b1, prev});
      idle_events();
      if (pushed < 1000 && !core_stall) begin
        ra = $urandom; rb = $urandom; rc = 5'($urandom_range(0, 31));
        set_bus(ra, rb, rc);
        if ($urandom_range(0, 2) == 0) begin
          cf_valid = 1'b1; q_cf.push_back({2'd0, 5'd0, rb, ra}); pushed++;
        end
        r = $urandom_range(0, 5);
        if (r == 0) begin
          mem_load = 1'b1; q_mem.push_back({2'd1, 3'b000, rc[1:0], 32'd0, ra}); pushed++;
        end else if (r == 1) begin
          mem_store = 1'b1; q_mem.push_back({2'd2, 3'b000, rc[1:0], rb, ra}); pushed++;
        end
        if ($urandom_range(0, 2) == 0) begin
          reg_valid = 1'b1; q_reg.push_back({2'd3, rc, 32'd0, ra}); pushed++;
        end
      end
      ev_out.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (ev_out.out_valid && ev_out.out_ready) begin
        beat = dut_beat(); have = 1'b0; exp_beat = '0;
        case (ev_out.out_kind)
          2'd0:      if (q_cf.size() > 0)  begin exp_beat = q_cf.pop_front();  have = 1'b1; end
          2'd3:      if (q_reg.size() > 0) begin exp_beat = q_reg.pop_front(); have = 1'b1; end
          default:   if (q_mem.size() > 0) begin exp_beat = q_mem.pop_front(); have = 1'b1; end
        endcase
        check("random beat expected", have, 1'b1);
        if (have) check("random beat order", beat, exp_beat);
        recv++;
      end
      pend = ev_out.out_valid && !ev_out.out_ready;
      prev = dut_beat();
      @(negedge clk);
    end
    idle_events();
    check("random pushed enough", pushed >= 1000, 1'b1);
    check("random nothing lost", recv, pushed);
    check("random queues empty", q_cf.size() + q_mem.size() + q_reg.size(), 0);
    check("random no drops", {overflow, drop_count}, 17'd0);

    do_reset();
    ev_out.out_ready = 1'b0; hold_on_store = 1'b1;
    set_bus(32'h40, 32'h41, 5'd2); mem_store = 1'b1;
    @(negedge clk);
    idle_events(); hold_on_store = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_bus(32'h500 + 32'(i), 32'h0, 5'd0); cf_valid = 1'b1;
      @(negedge clk);
    end
    idle_events();
    check("pre-reset out_valid", ev_out.out_valid, 1'b1);
    check("pre-reset store_hold", store_hold, 1'b1);
    rst = 1'b1;
    #1;
    check("stall masked during reset", core_stall, 1'b0);
    @(negedge clk);
    check("mid reset out_valid", ev_out.out_valid, 1'b0);
    check("mid reset store_hold", store_hold, 1'b0);
    check("mid reset core_stall", core_stall, 1'b0);
    rst = 1'b0; ev_out.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post reset empty %0d", i), ev_out.out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
